wb_mem_tester: RTL and testbench
================================

WB_MEM_TESTER -- requirements
Module: wb_mem_tester

Interface
REQ-001 Parameter ADR_WIDTH, default 11, SHALL set the number of 32-bit words tested to 2^ADR_WIDTH.
REQ-002 Parameter BURST_LEN, default 8, power of two from 2 to 2^ADR_WIDTH, SHALL set the number of beats per read burst.
REQ-003 Parameter TIMEOUT, default 255, SHALL set the maximum number of cycles to wait for ack on one beat.
REQ-004 Ports SHALL be one clock and one reset: the reset is asynchronous and active-high, and the ports are named clk and rst, matching the wishbone interface naming.
REQ-005 clk input 1: clock for all logic.
REQ-006 rst input 1: asynchronous, active-high reset.
REQ-007 start input 1: single-cycle request to run one test.
REQ-008 seed input 32: pattern seed, sampled on an accepted start.
REQ-009 wb_cyc, wb_stb, wb_we output 1 each: Wishbone master cycle, strobe and write-enable.
REQ-010 wb_adr output 32: byte address.
REQ-011 wb_dat_ms output 32 and wb_sel output 4: write data and byte select.
REQ-012 wb_cti output 3 and wb_bte output 2: cycle type and burst type.
REQ-013 wb_dat_sm input 32: read data.
REQ-014 wb_ack, wb_err, wb_rty inputs 1 each: slave responses.
REQ-015 busy output 1: test in progress.
REQ-016 done output 1: level, set at test end and cleared by the next accepted start.
REQ-017 pass output 1: valid while done is high.
REQ-018 err_count output 16: number of mismatching words, saturating.
REQ-019 first_err_adr output 32: byte address of the first mismatch.
REQ-020 abort output 1: test ended on wb_err or timeout.

Function
REQ-021 The state machine SHALL have the states IDLE, WRITE, READ, GAP and DONE.
REQ-022 start in IDLE or DONE SHALL move to WRITE on the next edge, latch seed, clear done, pass, err_count, first_err_adr and abort, and reset the word index i to 0; start in any other state SHALL be ignored.
REQ-023 Pattern SHALL be P(i) = (seed + i*32'h01010101) mod 2^32.
REQ-024 WRITE SHALL issue classic cycles:
- cyc = stb = we = 1, sel = 4'hF, cti = 3'b000, bte = 2'b00.
- adr = i<<2, dat_ms = P(i).
- All signals held stable until wb_ack.
REQ-025 On a WRITE ack, i SHALL increment in the same cycle, with cyc and stb staying high, so that a slave with combinational ack completes one word per cycle.
REQ-026 On the ack of the last word, the block SHALL drop cyc and stb for one cycle, reset i to 0, and enter READ.
REQ-027 READ SHALL issue incrementing bursts:
- we = 0, sel = 4'hF, bte = 2'b00, adr = i<<2.
- cti = 3'b010 for every beat except the last beat of the burst, which uses cti = 3'b111.
REQ-028 Read data SHALL be sampled only in cycles where wb_ack = 1.
- Each sampled word is compared with P(i).
- On mismatch, err_count increments (saturating at 16'hFFFF).
- first_err_adr is written only on the first mismatch.
REQ-029 After the beat with cti = 3'b111 is acknowledged, the block SHALL go to GAP, with cyc = stb = 0 for exactly one cycle, then return to READ, or go to DONE if i has reached 2^ADR_WIDTH.
REQ-030 In DONE, pass SHALL be 1 if and only if err_count = 0 and abort = 0.
REQ-031 Any wb_err in WRITE or READ SHALL set abort, drop cyc and stb on the next edge, and enter DONE.
REQ-032 wb_rty SHALL re-issue the same beat without advancing i.
REQ-033 A per-beat cycle counter SHALL be cleared on each ack; reaching TIMEOUT SHALL set abort and enter DONE.
REQ-034 If wb_ack and wb_err are high together, wb_err SHALL take priority.
REQ-035 busy SHALL be 1 in WRITE, READ and GAP, and 0 otherwise.
REQ-036 wb_stb SHALL never be high while wb_cyc is low.

Reset
REQ-037 rst SHALL immediately force:
- state IDLE;
- all wb_* outputs to 0;
- busy, done, pass and abort to 0;
- err_count and first_err_adr to 0.
REQ-038 Reset asserted mid-cycle SHALL drop cyc and stb without waiting for ack; after release, the block SHALL wait for a new start.

Verification
REQ-039 ADR_WIDTH = 4, BURST_LEN = 4, seed = 0, ideal memory slave -> 16 writes with dat_ms = i*32'h01010101, then 4 bursts with cti 010,010,010,111 -> done = 1, pass = 1, err_count = 0.
REQ-040 Same setup, slave corrupts the read data of word 5 -> err_count = 1, first_err_adr = 32'h14, pass = 0.
REQ-041 Slave asserts wb_err on the 3rd write -> abort = 1, done = 1, pass = 0; cyc is low on the next cycle.
REQ-042 Slave never acks, TIMEOUT = 255 -> abort = 1 after 255 cycles, with adr = 0 throughout.
REQ-043 rst asserted during READ burst beat 2 -> all outputs 0 in the same cycle; after release and start, a full pass is obtained.
REQ-044 start pulsed while busy -> ignored; no restart and i unchanged.

Source files
------------

// File: rtl/wb_mem_tester.sv
// Purpose: Wishbone memory tester; writes a seeded pattern to every word, then reads it back in bursts and compares.
// Latency: bus outputs are a pure function of registered state; a combinational-ack slave completes one word per cycle.
// Backpressure: each beat is held until ack/err; rty re-issues it; a per-beat cycle budget aborts a silent slave.
module wb_mem_tester #(
  parameter int ADR_WIDTH = 11,
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] seed,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat_ms,
  output logic [3:0]  wb_sel,
  output logic [2:0]  wb_cti,
  output logic [1:0]  wb_bte,
  input  logic [31:0] wb_dat_sm,
  input  logic        wb_ack,
  input  logic        wb_err,
  input  logic        wb_rty,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [31:0] first_err_adr,
  output logic        abort
);

  localparam int BW = $clog2(BURST_LEN);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  // One extra index bit flags that every word has been read back.
  logic [ADR_WIDTH:0] i_q, i_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [31:0]       seed_q, seed_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [31:0]       first_q, first_d;
  logic              abort_q, abort_d;

  logic [31:0]       beat_adr;
  logic [31:0]       pattern;
  logic              last_word;
  logic              last_beat;

  // Address and expected data of the current word, plus burst/array boundary flags.
  always_comb begin
    beat_adr  = 32'(i_q[ADR_WIDTH-1:0]) << 2;
    pattern   = seed_q + 32'(i_q[ADR_WIDTH-1:0]) * 32'h0101_0101;
    last_word = &i_q[ADR_WIDTH-1:0];
    last_beat = &i_q[BW-1:0];
  end

  // State register; reset returns to IDLE at once, which drops the bus without waiting for ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: word index, beat timer, latched seed and result bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q       <= '0;
      tmo_q     <= '0;
      seed_q    <= '0;
      err_cnt_q <= '0;
      first_q   <= '0;
      abort_q   <= 1'b0;
    end else begin
      i_q       <= i_d;
      tmo_q     <= tmo_d;
      seed_q    <= seed_d;
      err_cnt_q <= err_cnt_d;
      first_q   <= first_d;
      abort_q   <= abort_d;
    end
  end

  // Next state and datapath updates; err outranks ack, rty simply leaves the beat in place.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    tmo_d     = tmo_q;
    seed_d    = seed_q;
    err_cnt_d = err_cnt_q;
    first_d   = first_q;
    abort_d   = abort_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_WRITE;
          seed_d    = seed;
          i_d       = '0;
          tmo_d     = '0;
          err_cnt_d = '0;
          first_d   = '0;
          abort_d   = 1'b0;
        end
      end
      S_WRITE, S_READ: begin
        if (wb_err) begin
          abort_d = 1'b1;
          state_d = S_DONE;
        end else if (wb_ack) begin
          tmo_d = '0;
          i_d   = i_q + 1'b1;
          if (state_q == S_WRITE) begin
            if (last_word) begin
              i_d     = '0;
              state_d = S_GAP;
            end
          end else begin
            if (wb_dat_sm != pattern) begin
              if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
              if (err_cnt_q == 16'd0)    first_d   = beat_adr;
            end
            if (last_beat) state_d = S_GAP;
          end
        end else if (wb_rty) begin
          tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          abort_d = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_GAP: begin
        tmo_d   = '0;
        state_d = i_q[ADR_WIDTH] ? S_DONE : S_READ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus and status outputs decoded from the registered state only.
  always_comb begin
    wb_cyc    = 1'b0;
    wb_stb    = 1'b0;
    wb_we     = 1'b0;
    wb_adr    = '0;
    wb_dat_ms = '0;
    wb_sel    = '0;
    wb_cti    = 3'b000;
    wb_bte    = 2'b00;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_WRITE: begin
        wb_cyc    = 1'b1;
        wb_stb    = 1'b1;
        wb_we     = 1'b1;
        wb_adr    = beat_adr;
        wb_dat_ms = pattern;
        wb_sel    = 4'hF;
        busy      = 1'b1;
      end
      S_READ: begin
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        wb_adr = beat_adr;
        wb_sel = 4'hF;
        wb_cti = last_beat ? 3'b111 : 3'b010;
        busy   = 1'b1;
      end
      S_GAP:  busy = 1'b1;
      S_DONE: done = 1'b1;
      default: ;
    endcase
    pass          = done && (err_cnt_q == 16'd0) && !abort_q;
    err_count     = err_cnt_q;
    first_err_adr = first_q;
    abort         = abort_q;
  end

endmodule

// File: tb/tb_wb_mem_tester.sv
// Directed bench for wb_mem_tester with a 16-word behavioural memory slave.
// Slave acks combinationally; knobs inject read corruption, a write error or a silent slave.
// Every bus beat is logged with its cycle stamp so burst shape and gaps can be checked afterwards.
module tb_wb_mem_tester;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] seed;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat_ms, wb_dat_sm;
  logic [3:0]  wb_sel;
  logic [2:0]  wb_cti;
  logic [1:0]  wb_bte;
  logic        wb_ack, wb_err, wb_rty;
  logic        busy, done, pass, abort;
  logic [15:0] err_count;
  logic [31:0] first_err_adr;

  // slave knobs
  logic        noack      = 1'b0;
  logic        err_mode   = 1'b0;
  logic        corrupt_en = 1'b0;
  logic [3:0]  corrupt_idx = 4'd0;

  int tests = 0;
  int fails = 0;
  int cyc_num = 0;
  int stb_viol = 0;

  logic [31:0] mem [16];
  logic [31:0] lg_adr[$];
  logic [31:0] lg_dat[$];
  logic        lg_we[$];
  logic [2:0]  lg_cti[$];
  int          lg_cyc[$];

  wb_mem_tester #(.ADR_WIDTH(4), .BURST_LEN(4), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_ms(wb_dat_ms), .wb_sel(wb_sel), .wb_cti(wb_cti), .wb_bte(wb_bte),
    .wb_dat_sm(wb_dat_sm), .wb_ack(wb_ack), .wb_err(wb_err), .wb_rty(wb_rty),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_adr(first_err_adr), .abort(abort)
  );

  always #5 clk = ~clk;

  assign wb_ack    = wb_cyc & wb_stb & ~noack;
  assign wb_err    = wb_cyc & wb_stb & wb_we & err_mode & (wb_adr == 32'h8);
  assign wb_rty    = 1'b0;
  assign wb_dat_sm = mem[wb_adr[5:2]] ^
                     ((corrupt_en && wb_adr[5:2] == corrupt_idx) ? 32'h0000_0100 : 32'h0);

  always @(posedge clk) begin
    cyc_num <= cyc_num + 1;
    if (!rst && wb_cyc && wb_stb && wb_we && wb_ack && !wb_err)
      mem[wb_adr[5:2]] <= wb_dat_ms;
    if (!rst && wb_cyc && wb_stb && wb_ack && !wb_err) begin
      lg_adr.push_back(wb_adr);
      lg_dat.push_back(wb_dat_ms);
      lg_we.push_back(wb_we);
      lg_cti.push_back(wb_cti);
      lg_cyc.push_back(cyc_num);
    end
  end

  always @(negedge clk) begin
    if (wb_stb && !wb_cyc) stb_viol <= stb_viol + 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_start(input logic [31:0] s);
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, done, 1'b1);
  endtask

  initial begin
    int base;
    int n_cyc;
    int bad_adr;
    int n;

    rst   = 1'b1;
    start = 1'b0;
    seed  = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_bus", {wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_cti}, '0);
    chk("rst_status", {busy, done, pass, abort, err_count, first_err_adr}, '0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_start", {busy, wb_cyc}, '0);

    // A: seed 0, ideal slave -> 16 writes, 4 bursts of 4, pass
    base = lg_adr.size();
    run_start(32'h0);
    chk("A_busy", busy, 1'b1);
    wait_done("A_done");
    chk("A_pass", pass, 1'b1);
    chk("A_errcnt", err_count, 16'd0);
    chk("A_abort", abort, 1'b0);
    chk("A_nbeats", lg_adr.size() - base, 32);
    if (lg_adr.size() - base == 32) begin
      for (int k = 0; k < 32; k++) begin
        if (k < 16) begin
          chk($sformatf("A_we%0d", k), lg_we[base+k], 1'b1);
          chk($sformatf("A_wadr%0d", k), lg_adr[base+k], k * 4);
          chk($sformatf("A_wdat%0d", k), lg_dat[base+k], k * 32'h0101_0101);
          chk($sformatf("A_wcti%0d", k), lg_cti[base+k], 3'b000);
        end else begin
          chk($sformatf("A_rwe%0d", k - 16), lg_we[base+k], 1'b0);
          chk($sformatf("A_radr%0d", k - 16), lg_adr[base+k], (k - 16) * 4);
          chk($sformatf("A_rcti%0d", k - 16), lg_cti[base+k],
              (((k - 16) % 4) == 3) ? 3'b111 : 3'b010);
        end
        if (k > 0)
          chk($sformatf("A_gap%0d", k), lg_cyc[base+k] - lg_cyc[base+k-1],
              (k == 16 || (k > 16 && ((k - 16) % 4) == 0)) ? 2 : 1);
      end
    end

    // B: corrupted word 5, nonzero seed; start clears done
    corrupt_en  = 1'b1;
    corrupt_idx = 4'd5;
    base = lg_adr.size();
    run_start(32'h1234_5678);
    chk("B_done_cleared", done, 1'b0);
    chk("B_busy", busy, 1'b1);
    wait_done("B_done");
    chk("B_errcnt", err_count, 16'd1);
    chk("B_first", first_err_adr, 32'h14);
    chk("B_pass", pass, 1'b0);
    chk("B_abort", abort, 1'b0);
    if (lg_dat.size() - base > 3) chk("B_wdat3", lg_dat[base+3], 32'h1537_597B);
    else chk("B_wdat3_missing", lg_dat.size() - base, 4);
    corrupt_en = 1'b0;

    // C: wb_err (with ack) on the 3rd write
    err_mode = 1'b1;
    run_start(32'h0);
    n = 0;
    while (!wb_err && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("C_err_seen", wb_err, 1'b1);
    chk("C_err_adr", wb_adr, 32'h8);
    @(negedge clk);
    chk("C_cyc_low", {wb_cyc, wb_stb}, 2'b00);
    chk("C_status", {done, abort, pass}, 3'b110);
    err_mode = 1'b0;

    // D: silent slave -> timeout after 255 cycles, address stays 0
    noack = 1'b1;
    run_start(32'h0);
    n_cyc = 0;
    bad_adr = 0;
    for (int k = 0; k < 400; k++) begin
      if (done) break;
      if (wb_cyc) begin
        n_cyc++;
        if (wb_adr != 32'h0) bad_adr++;
      end
      @(negedge clk);
    end
    chk("D_done", done, 1'b1);
    chk("D_cycles", n_cyc, 255);
    chk("D_adr_stable", bad_adr, 0);
    chk("D_abort", {abort, pass}, 2'b10);
    noack = 1'b0;

    // E: reset during read beat 2 with a mismatch already counted
    corrupt_en  = 1'b1;
    corrupt_idx = 4'd1;
    run_start(32'h0);
    n = 0;
    while (!(wb_cyc && !wb_we && wb_adr == 32'h8) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("E_reach_beat2", {wb_cyc, wb_we, wb_adr}, {1'b1, 1'b0, 32'h8});
    chk("E_pre_errcnt", err_count, 16'd1);
    rst = 1'b1;
    #1;
    chk("E_rst_all_zero", {wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_ms, wb_sel, wb_cti, wb_bte,
                           busy, done, pass, abort, err_count, first_err_adr}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    corrupt_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("E_waits_start", {busy, wb_cyc, done}, 3'b000);

    // F: full run after reset; start while busy is ignored
    base = lg_adr.size();
    run_start(32'hA5A5_0001);
    n = 0;
    while (!(wb_we && wb_adr == 32'h14) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("F_reach_w5", wb_adr, 32'h14);
    seed  = 32'hFFFF_FFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("F_no_restart_adr", wb_adr, 32'h18);
    chk("F_no_restart_dat", wb_dat_ms, 32'hABAB_0607);
    chk("F_busy", busy, 1'b1);
    wait_done("F_done");
    chk("F_pass", {pass, abort, err_count}, {1'b1, 1'b0, 16'd0});
    if (lg_dat.size() - base > 7) chk("F_wdat7", lg_dat[base+7], 32'hACAC_0708);
    else chk("F_wdat7_missing", lg_dat.size() - base, 8);

    chk("stb_without_cyc", stb_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
